// File: rtl/pipe_buf_pkg.sv
// Shared constants and types for the pipeline skid buffer.
// Build option: PIPE_SKID_STALL_CNT_EN adds the saturating stall counter.
package pipe_buf_pkg;

    // State encoding doubles as the occupancy count.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    localparam int unsigned               STALL_CNT_W   = 16;
    localparam logic [STALL_CNT_W-1:0]    STALL_CNT_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        StEmpty = ST_EMPTY,
        StOne   = ST_ONE,
        StFull  = ST_FULL
    } state_e;

endpackage

// File: rtl/pipe_skid_buffer_if.sv
// Valid/ready stream link between pipeline stages.
// The producer uses the master modport, the consumer the slave modport.
interface pipe_skid_buffer_if #(
    parameter int unsigned WIDTH = 16
) ();

    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (
        output valid,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        output ready
    );

endinterface

// File: rtl/pipe_skid_buffer.sv
// Two-entry skid buffer on the receiving end of a pipeline link.
// Words appear downstream one cycle after acceptance; in_ready is decoded from
// the state register only, so it never depends on out_ready.
// Build option: PIPE_SKID_STALL_CNT_EN adds the stall_cnt port and counter.
module pipe_skid_buffer
    import pipe_buf_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    pipe_skid_buffer_if.slave  in_if,
    pipe_skid_buffer_if.master out_if,
    output logic [1:0]         occupancy
`ifdef PIPE_SKID_STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

    state_e           state_q;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             in_xfer;
    logic             out_xfer;

    // Handshake flags and outputs decoded straight from registered state.
    always_comb begin
        in_if.ready  = (state_q != StFull);
        out_if.valid = (state_q != StEmpty);
        out_if.data  = main_q;
        occupancy    = state_q;
        in_xfer      = in_if.valid && in_if.ready;
        out_xfer     = out_if.valid && out_if.ready;
    end

    // Occupancy FSM with main/skid storage; reset and flush both discard everything.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state_q <= StEmpty;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (in_xfer) begin
                        main_q  <= in_if.data;
                        state_q <= StOne;
                    end
                end
                StOne: begin
                    if (in_xfer && out_xfer) begin
                        main_q <= in_if.data;
                    end else if (in_xfer) begin
                        // Downstream stalled: park the new word behind the head.
                        skid_q  <= in_if.data;
                        state_q <= StFull;
                    end else if (out_xfer) begin
                        // main_q keeps its stale value; out_valid masks it.
                        state_q <= StEmpty;
                    end
                end
                StFull: begin
                    if (out_xfer) begin
                        main_q  <= skid_q;
                        state_q <= StOne;
                    end
                end
                default: begin
                    state_q <= StEmpty;
                end
            endcase
        end
    end

`ifdef PIPE_SKID_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cnt_q;

    // Count cycles where a word waits on downstream; saturates, cleared by reset only.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (out_if.valid && !out_if.ready && (stall_cnt_q != STALL_CNT_MAX)) begin
            stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_skid_buffer.sv
// Self-checking bench for pipe_skid_buffer using a queue scoreboard.
// With PIPE_SKID_STALL_CNT_EN defined the stall counter is exercised too.
module tb_pipe_skid_buffer;

    localparam int unsigned W = 16;

    typedef struct packed {
        logic         fl;
        logic         rs;
        logic         v;
        logic [W-1:0] d;
        logic         r;
    } step_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         flush;
    logic [1:0]   occupancy;
`ifdef PIPE_SKID_STALL_CNT_EN
    logic [15:0]  stall_cnt;
`endif

    int           n_cmp = 0;
    int           n_bad = 0;
    logic [W-1:0] sb [$];

    pipe_skid_buffer_if #(.WIDTH(W)) up_if ();
    pipe_skid_buffer_if #(.WIDTH(W)) dn_if ();

    pipe_skid_buffer #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_if     (up_if),
        .out_if    (dn_if),
        .occupancy (occupancy)
`ifdef PIPE_SKID_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({up_if.ready, dn_if.valid, dn_if.data, occupancy} !== {1'b1, 1'b0, 16'h0000, 2'd0}) begin
            n_bad++;
            $display("FAIL reset_values: got in_ready=%0b out_valid=%0b out_data=%h occ=%0d, want 1 0 0000 0",
                     up_if.ready, dn_if.valid, dn_if.data, occupancy);
        end
`ifdef PIPE_SKID_STALL_CNT_EN
        n_cmp++;
        if (stall_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt);
        end
`endif
        reset = 1'b0;
        sb.delete();
    endtask

    task automatic test_single();
        @(negedge clk);
        up_if.valid = 1'b1;
        up_if.data  = 16'h1234;
        dn_if.ready = 1'b1;
        n_cmp++;
        if (up_if.ready !== 1'b1) begin
            n_bad++;
            $display("FAIL single_in_ready: got %0b want 1", up_if.ready);
        end
        @(negedge clk);
        up_if.valid = 1'b0;
        n_cmp++;
        if ({dn_if.valid, dn_if.data, occupancy} !== {1'b1, 16'h1234, 2'd1}) begin
            n_bad++;
            $display("FAIL single_out: got valid=%0b data=%h occ=%0d, want 1 1234 1",
                     dn_if.valid, dn_if.data, occupancy);
        end
        @(negedge clk);
        n_cmp++;
        if ({dn_if.valid, occupancy} !== {1'b0, 2'd0}) begin
            n_bad++;
            $display("FAIL single_drain: got valid=%0b occ=%0d, want 0 0", dn_if.valid, occupancy);
        end
    endtask

    task automatic test_stream();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            up_if.valid = (i < 8);
            up_if.data  = W'(i + 1);
            dn_if.ready = 1'b1;
            n_cmp++;
            if ({occupancy, up_if.ready, dn_if.valid} !== {2'(sb.size()), sb.size() != 2, sb.size() != 0}) begin
                n_bad++;
                $display("FAIL stream_state: got occ=%0d in_ready=%0b out_valid=%0b, want occ=%0d",
                         occupancy, up_if.ready, dn_if.valid, sb.size());
            end
            if (dn_if.valid && sb.size() != 0) begin
                n_cmp++;
                if (dn_if.data !== sb[0]) begin
                    n_bad++;
                    $display("FAIL stream_data: got %h want %h", dn_if.data, sb[0]);
                end
            end
            if (dn_if.valid && dn_if.ready && sb.size() != 0) void'(sb.pop_front());
            if (up_if.valid && up_if.ready) sb.push_back(up_if.data);
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] words [3];
        int           idx;
        words = '{16'hA001, 16'hA002, 16'hA003};
        idx   = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            dn_if.ready = (i >= 4);
            up_if.valid = (idx < 3);
            up_if.data  = (idx < 3) ? words[idx] : '0;
            if (i == 3) begin
                n_cmp++;
                if ({occupancy, up_if.ready} !== {2'd2, 1'b0}) begin
                    n_bad++;
                    $display("FAIL bp_full: got occ=%0d in_ready=%0b, want 2 0", occupancy, up_if.ready);
                end
            end
            n_cmp++;
            if ({occupancy, up_if.ready, dn_if.valid} !== {2'(sb.size()), sb.size() != 2, sb.size() != 0}) begin
                n_bad++;
                $display("FAIL bp_state: got occ=%0d in_ready=%0b out_valid=%0b, want occ=%0d",
                         occupancy, up_if.ready, dn_if.valid, sb.size());
            end
            if (dn_if.valid && sb.size() != 0) begin
                n_cmp++;
                if (dn_if.data !== sb[0]) begin
                    n_bad++;
                    $display("FAIL bp_data: got %h want %h", dn_if.data, sb[0]);
                end
            end
            if (dn_if.valid && dn_if.ready && sb.size() != 0) void'(sb.pop_front());
            if (up_if.valid && up_if.ready) begin
                sb.push_back(up_if.data);
                idx++;
            end
        end
        n_cmp++;
        if (idx !== 3) begin
            n_bad++;
            $display("FAIL bp_accepted: got %0d words accepted want 3", idx);
        end
    endtask

    // Table-driven run shared by the flush and mid-operation reset scenarios.
    task automatic run_steps(input string name, input step_t steps [$]);
        logic prev_clr;
        prev_clr = 1'b0;
        foreach (steps[k]) begin
            @(negedge clk);
            flush       = steps[k].fl;
            reset       = steps[k].rs;
            up_if.valid = steps[k].v;
            up_if.data  = steps[k].d;
            dn_if.ready = steps[k].r;
            if (prev_clr) begin
                n_cmp++;
                if (dn_if.data !== '0) begin
                    n_bad++;
                    $display("FAIL %s_cleared_data: got %h want 0000", name, dn_if.data);
                end
            end
            n_cmp++;
            if ({occupancy, up_if.ready, dn_if.valid} !== {2'(sb.size()), sb.size() != 2, sb.size() != 0}) begin
                n_bad++;
                $display("FAIL %s_state: got occ=%0d in_ready=%0b out_valid=%0b, want occ=%0d",
                         name, occupancy, up_if.ready, dn_if.valid, sb.size());
            end
            if (dn_if.valid && sb.size() != 0) begin
                n_cmp++;
                if (dn_if.data !== sb[0]) begin
                    n_bad++;
                    $display("FAIL %s_data: got %h want %h", name, dn_if.data, sb[0]);
                end
            end
            if (steps[k].fl || steps[k].rs) begin
                sb.delete();
            end else begin
                if (dn_if.valid && dn_if.ready && sb.size() != 0) void'(sb.pop_front());
                if (up_if.valid && up_if.ready) sb.push_back(up_if.data);
            end
            prev_clr = steps[k].fl || steps[k].rs;
        end
        flush = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_flush();
        step_t steps [$];
        steps = '{
            '{1'b0, 1'b0, 1'b1, 16'hC001, 1'b0},
            '{1'b0, 1'b0, 1'b1, 16'hC002, 1'b0},
            '{1'b1, 1'b0, 1'b1, 16'hBEEF, 1'b0},  // flush while FULL
            '{1'b0, 1'b0, 1'b1, 16'hC003, 1'b0},
            '{1'b1, 1'b0, 1'b1, 16'hBEEF, 1'b1},  // flush while ONE, in_ready high
            '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1},
            '{1'b0, 1'b0, 1'b1, 16'hC004, 1'b1},
            '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1},
            '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1}
        };
        run_steps("flush", steps);
    endtask

    task automatic test_reset_mid();
        step_t steps [$];
        steps = '{
            '{1'b0, 1'b0, 1'b1, 16'hE001, 1'b0},
            '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0},  // reset while ONE, stalled
            '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1},
            '{1'b0, 1'b0, 1'b1, 16'hE002, 1'b1},
            '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1},
            '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1}
        };
        run_steps("rstmid", steps);
    endtask

`ifdef PIPE_SKID_STALL_CNT_EN
    task automatic test_stall_cnt();
        @(negedge clk);
        reset       = 1'b1;
        up_if.valid = 1'b0;
        dn_if.ready = 1'b0;
        @(negedge clk);
        reset       = 1'b0;
        up_if.valid = 1'b1;
        up_if.data  = 16'hF001;
        repeat (5) begin
            @(negedge clk);
            up_if.valid = 1'b0;
        end
        @(negedge clk);
        n_cmp++;
        if (stall_cnt !== 16'd5) begin
            n_bad++;
            $display("FAIL stall_count: got %0d want 5", stall_cnt);
        end
        dn_if.ready = 1'b1;
        flush       = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_cmp++;
        if (stall_cnt !== 16'd5) begin
            n_bad++;
            $display("FAIL stall_after_flush: got %0d want 5", stall_cnt);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_cmp++;
        if (stall_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL stall_after_reset: got %0d want 0", stall_cnt);
        end
    endtask
`endif

    initial begin
        reset       = 1'b1;
        flush       = 1'b0;
        up_if.valid = 1'b0;
        up_if.data  = '0;
        dn_if.ready = 1'b0;
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_flush();
        test_reset_mid();
`ifdef PIPE_SKID_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pipe_skid_buffer.md
Name: pipe_skid_buffer

Overview:
- Receiving end of an inter-stage pipeline link, with valid/ready backpressure.
- Accepts one word per cycle from the upstream stage and presents it to the downstream stage one cycle later.
- Absorbs a downstream stall with a second "skid" entry. in_ready never depends combinationally on out_ready.
- Flush inserts a bubble, for branch or hazard recovery in the five-stage pipeline.

Parameters:
- WIDTH, 16, data word width in bits.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous pipeline flush; discards all held words.
- in_valid  input  1  upstream word present.
- in_ready  output  1  buffer can accept a word this cycle.
- in_data  input  WIDTH  upstream word.
- out_valid  output  1  out_data holds a valid word.
- out_ready  input  1  downstream consumes out_data this cycle.
- out_data  output  WIDTH  word presented downstream.
- occupancy  output  2  number of held words, 0..2.
- stall_cnt  output  16  present only with PIPE_SKID_STALL_CNT_EN.

Behaviour:
- Storage and handshake:
  - Storage: main register (drives out_data) and skid register, each WIDTH bits.
  - The state register encodes occupancy: EMPTY=0, ONE=1, FULL=2.
  - Input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
  - in_ready = (state != FULL), decoded from the state register only.
  - out_valid = (state != EMPTY).
  - occupancy = state.
- Latency: a word accepted at edge N is visible on out_data/out_valid after edge N. There is no same-cycle pass-through.
- Transitions per posedge, in priority order:
  - reset: state EMPTY; main and skid registers cleared to 0. Applies mid-operation too; held words are lost.
  - flush (not reset): state EMPTY; main and skid registers cleared to 0. An input offered in the same cycle is dropped, even though in_ready was 1.
  - EMPTY: input transfer -> main<=in_data, ONE. Otherwise stay.
  - ONE, input and output transfer together -> main<=in_data, stay ONE.
  - ONE, input transfer only -> skid<=in_data, FULL.
  - ONE, output transfer only -> EMPTY. The main register retains its stale value.
  - ONE, neither -> hold.
  - FULL (in_ready=0, in_valid ignored): output transfer -> main<=skid, ONE. Otherwise hold.
- Ordering: words leave in strict acceptance order. No word is duplicated or lost, except by flush or reset.
- out_data is stable while out_valid && !out_ready.
- Reset values: in_ready=1, out_valid=0, out_data=0, occupancy=0, stall_cnt=0.

Optional Feature:
- Macro: PIPE_SKID_STALL_CNT_EN.
- Defined:
  - stall_cnt port exists: a 16-bit counter incremented on each posedge where out_valid && !out_ready.
  - It saturates at 16'hFFFF.
  - Cleared by reset only; flush does not clear it.
- Undefined: stall_cnt port and counter logic are absent; all other behaviour is identical.

Decomposition:
- Shared package pipe_buf_pkg:
  - state constants ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2.
  - STALL_CNT_W=16 and STALL_CNT_MAX=16'hFFFF.
- No sub-module: the data registers and the state register are small enough to stay in one module.

Test Plan:
- Reset, then in_valid=1, in_data=16'h1234, out_ready=1 held -> out_valid=1, out_data=16'h1234 one cycle after accept; occupancy=1.
- Streaming: 8 words 16'h0001..16'h0008 on consecutive cycles, out_ready=1 -> same sequence out, one cycle later, in_ready stays 1 throughout.
- Backpressure: out_ready=0 while offering 16'hA001, 16'hA002, 16'hA003 -> first two accepted, occupancy=2, in_ready=0, 16'hA003 held upstream. Release out_ready -> output order A001, A002, A003 with no loss.
- Flush while FULL, with in_valid=1 and in_data=16'hBEEF on the same cycle -> next cycle occupancy=0, out_valid=0, out_data=0, in_ready=1; BEEF never appears.
- Reset asserted while ONE with out_ready=0 -> next cycle all outputs at reset values; previously held word never appears.
- PIPE_SKID_STALL_CNT_EN defined: hold out_valid=1, out_ready=0 for 5 cycles -> stall_cnt=5; a following flush leaves stall_cnt=5; reset -> 0.
